pulse_period_meter: RTL and testbench

//   Receive-side companion to the tick-pulse clock divider: measures the clk-cycle

---
 rtl/pulse_period_meter_if.sv | 30 +++
 rtl/pulse_period_meter.sv | 74 +++++++
 tb/tb_pulse_period_meter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pulse_period_meter_if.sv
// Signal bundle between a tick-pulse source and the period meter.
// The meter sits on the slave side; the pulse source and monitor sit on the master side.
interface pulse_period_meter_if #(
  parameter int unsigned CNT_W = 26
);
  logic             pulse_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             is_fast;
  logic             timeout;
  logic             measuring;

  modport master (
    output pulse_in,
    input  period,
    input  period_valid,
    input  is_fast,
    input  timeout,
    input  measuring
  );

  modport slave (
    input  pulse_in,
    output period,
    output period_valid,
    output is_fast,
    output timeout,
    output measuring
  );
endinterface

// File: rtl/pulse_period_meter.sv
// Measures clk-cycle spacing between tick pulses, classifies each period as fast/slow
// and flags a timeout when no pulse arrives within TIMEOUT cycles.
module pulse_period_meter #(
  parameter int unsigned CNT_W    = 26,
  parameter int unsigned FAST_MAX = 5000000,
  parameter int unsigned TIMEOUT  = 50000000
) (
  input  logic                 clk,
  input  logic                 rst,
  pulse_period_meter_if.slave  bus_io
);

  localparam logic [CNT_W-1:0] FastMaxCnt = CNT_W'(FAST_MAX);
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  typedef enum logic [0:0] {StIdle, StMeasure} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] period_q;
  logic             period_valid_q;
  logic             is_fast_q;
  logic             timeout_q;
  logic             measuring_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      is_fast_q      <= 1'b0;
      timeout_q      <= 1'b0;
      measuring_q    <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (bus_io.pulse_in) begin
            state_q     <= StMeasure;
            cnt_q       <= CntOne;
            measuring_q <= 1'b1;
          end
        end
        StMeasure: begin
          // A pulse on the terminal count still wins over the timeout.
          if (bus_io.pulse_in) begin
            period_q       <= cnt_q;
            is_fast_q      <= (cnt_q <= FastMaxCnt);
            period_valid_q <= 1'b1;
            cnt_q          <= CntOne;
          end else if (cnt_q == TimeoutCnt) begin
            timeout_q   <= 1'b1;
            cnt_q       <= '0;
            state_q     <= StIdle;
            measuring_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
      endcase
    end
  end

  assign bus_io.period       = period_q;
  assign bus_io.period_valid = period_valid_q;
  assign bus_io.is_fast      = is_fast_q;
  assign bus_io.timeout      = timeout_q;
  assign bus_io.measuring    = measuring_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench for pulse_period_meter: table-driven pulse trains plus hand-written
// corner sequences; expected strobes are queued and matched as the DUT emits them.
module tb_pulse_period_meter;

  localparam int unsigned CntW    = 8;
  localparam int unsigned FastMax = 10;
  localparam int unsigned Tmo     = 40;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   last_edge = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  pulse_period_meter_if #(.CNT_W(CntW)) bus ();

  pulse_period_meter #(
    .CNT_W    (CntW),
    .FAST_MAX (FastMax),
    .TIMEOUT  (Tmo)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit        is_to;
    int        cyc;
    logic [7:0] period;
    bit        fast;
  } ev_t;

  typedef struct {
    int         spacing;
    int         n_pulses;
    logic [7:0] exp_period;
    bit         exp_fast;
  } vec_t;

  ev_t  exp_q[$];
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input bit p);
    @(negedge clk);
    bus.pulse_in = p;
    last_edge = cyc + 1;
  endtask

  task automatic push_ev(input bit is_to, input int c, input logic [7:0] p, input bit f);
    ev_t e;
    e.is_to  = is_to;
    e.cyc    = c;
    e.period = p;
    e.fast   = f;
    exp_q.push_back(e);
  endtask

  task automatic check_drained(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Scoreboard: every strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (bus.period_valid === 1'b1 || bus.timeout === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {30'd0, bus.timeout, bus.period_valid}, 0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("strobe_kind", {31'd0, bus.timeout}, {31'd0, e.is_to});
        check("strobe_cycle", cyc, e.cyc);
        check("period", {24'd0, bus.period}, {24'd0, e.period});
        check("is_fast", {31'd0, bus.is_fast}, {31'd0, e.fast});
      end
    end
  end

  task automatic run_vec(input vec_t v);
    for (int k = 0; k < v.n_pulses; k++) begin
      if (k > 0) repeat (v.spacing - 1) tick(1'b0);
      tick(1'b1);
      if (k > 0) push_ev(1'b0, last_edge, v.exp_period, v.exp_fast);
    end
    push_ev(1'b1, last_edge + Tmo, v.exp_period, v.exp_fast);
    repeat (Tmo + 5) tick(1'b0);
    check("measuring_after_timeout", {31'd0, bus.measuring}, 0);
    check_drained("vec_pending");
  endtask

  initial begin
    int p;
    vecs[0] = '{spacing: 20, n_pulses: 2, exp_period: 8'd20, exp_fast: 1'b0};
    vecs[1] = '{spacing: 4,  n_pulses: 5, exp_period: 8'd4,  exp_fast: 1'b1};
    vecs[2] = '{spacing: 10, n_pulses: 2, exp_period: 8'd10, exp_fast: 1'b1};
    vecs[3] = '{spacing: 11, n_pulses: 2, exp_period: 8'd11, exp_fast: 1'b0};
    vecs[4] = '{spacing: 40, n_pulses: 2, exp_period: 8'd40, exp_fast: 1'b0};
    vecs[5] = '{spacing: 1,  n_pulses: 3, exp_period: 8'd1,  exp_fast: 1'b1};
    vecs[6] = '{spacing: 7,  n_pulses: 3, exp_period: 8'd7,  exp_fast: 1'b1};

    rst = 1'b1;
    bus.pulse_in = 1'b0;
    tick(1'b0);
    tick(1'b0);
    check("rst_period", {24'd0, bus.period}, 0);
    check("rst_period_valid", {31'd0, bus.period_valid}, 0);
    check("rst_is_fast", {31'd0, bus.is_fast}, 0);
    check("rst_timeout", {31'd0, bus.timeout}, 0);
    check("rst_measuring", {31'd0, bus.measuring}, 0);
    rst = 1'b0;
    tick(1'b0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Lone pulse: timeout 40 cycles later, period held, then a restart without a strobe.
    tick(1'b1);
    p = last_edge;
    push_ev(1'b1, p + Tmo, 8'd7, 1'b1);
    tick(1'b0);
    check("measuring_after_pulse", {31'd0, bus.measuring}, 1);
    repeat (Tmo + 4) tick(1'b0);
    check("measuring_after_lone", {31'd0, bus.measuring}, 0);
    check("period_held", {24'd0, bus.period}, 7);
    tick(1'b1);
    push_ev(1'b1, last_edge + Tmo, 8'd7, 1'b1);
    repeat (Tmo + 5) tick(1'b0);
    check_drained("lone_pending");

    // Spacing 41: first pulse times out, second restarts silently.
    tick(1'b1);
    push_ev(1'b1, last_edge + Tmo, 8'd7, 1'b1);
    repeat (Tmo) tick(1'b0);
    tick(1'b1);
    push_ev(1'b1, last_edge + Tmo, 8'd7, 1'b1);
    repeat (Tmo + 5) tick(1'b0);
    check_drained("gap41_pending");

    // Reset mid-measurement with cnt at 15.
    tick(1'b1);
    repeat (14) tick(1'b0);
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
    check("midrst_measuring", {31'd0, bus.measuring}, 0);
    check("midrst_period_valid", {31'd0, bus.period_valid}, 0);
    check("midrst_period", {24'd0, bus.period}, 0);
    repeat (3) tick(1'b0);
    check_drained("midrst_pending");
    run_vec('{spacing: 7, n_pulses: 2, exp_period: 8'd7, exp_fast: 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
